malzeme_dagitici: RTL and testbench
===================================

Name: malzeme_dagitici

Overview:
Consumer end of the ingredient-selection interface. It takes one order (selected line, quantity, salt flag, `bitti` strobe) from the selection unit and turns it into timed actuator commands. The sauce pump runs one fixed-length slot per unit, then the salt valve opens, then a one-cycle completion pulse fires. It sits between the selection unit and the physical pump/valve drivers.

Parameters:
- BIRIM_SURE, 4, clock cycles per dispensed unit (legal range 1..15)
- TUZ_SURE, 3, clock cycles the salt valve stays open (legal range 1..15)

Ports:
- saat  input  1  system clock, rising-edge active
- reset_n  input  1  asynchronous, active-low reset
- bitti  input  1  order-valid level from the selection unit; a new order is its rising edge
- secilen_malzeme  input  1  1 = sauce line selected, 0 = no pumped ingredient
- malzeme_miktari  input  4  units to dispense, 0..15
- cikis_tuzlu  input  1  1 = add salt after pumping
- iptal  input  1  synchronous abort, active-high
- pompa  output  1  sauce pump enable
- tuz_valf  output  1  salt valve enable
- birim_darbe  output  1  one-cycle pulse in the last cycle of each unit
- kalan  output  4  units still to dispense
- mesgul  output  1  high whenever the state is not BOS
- tamam  output  1  one-cycle pulse when an order completes

Behaviour:
- Interface: one clock (saat). reset_n is asynchronous and active-low.
- States: BOS (idle), DAGIT (pumping), TUZ (salting), TAMAM (done). Outputs are decoded from registered state and counters only (Moore); no combinational path from inputs to outputs.
- Reset (reset_n=0, asynchronous):
  - state = BOS
  - pompa, tuz_valf, birim_darbe, mesgul, tamam = 0; kalan = 0
  - unit/cycle counter = 0; bitti edge register = 0
  - Reset asserted mid-order aborts it immediately with no tamam pulse.
- Edge detect: bitti_q <= bitti every cycle in every state. Accept condition = bitti & ~bitti_q & state==BOS & ~iptal.
  - Because bitti_q resets to 0, bitti already high at reset release is accepted at the first clock edge.
- Accept (edge k): latch secim, miktar, tuzlu. Next state after edge k:
  - secim=1 and miktar!=0 -> DAGIT; kalan = miktar
  - else if tuzlu=1 -> TUZ; kalan = 0
  - else -> TAMAM (empty order still completes); kalan = 0
- DAGIT:
  - pompa=1; cycle counter runs 0..BIRIM_SURE-1.
  - In the cycle where counter = BIRIM_SURE-1: birim_darbe=1, and kalan decrements at the following edge.
  - When kalan would reach 0: next state TUZ if tuzlu, else TAMAM.
  - Duration is exactly miktar*BIRIM_SURE cycles.
- TUZ: tuz_valf=1 for exactly TUZ_SURE cycles, then TAMAM.
- TAMAM: tamam=1 for exactly one cycle, then BOS. mesgul is still 1 during TAMAM.
- Latency: first pompa/tuz_valf cycle is the cycle right after accept edge k.
- No queuing:
  - bitti edges while not in BOS are discarded.
  - bitti held high through completion does not re-trigger; a fresh 0->1 transition is required.
- iptal:
  - In any non-BOS state -> BOS at the next edge. kalan=0, counters cleared, pompa/tuz_valf drop, no tamam pulse.
  - iptal and a rising bitti in the same cycle: iptal wins and the order is dropped.
- Latched order fields are not affected by input changes after accept.
- kalan holds 0 in BOS after completion or abort.

Test Plan:
1. Reset: reset_n=0 while in DAGIT with kalan=5 -> pompa=0, kalan=0, mesgul=0 without waiting for a clock edge. Release with bitti=0 -> remains in BOS.
2. secim=1, miktar=7, tuzlu=0, bitti 0->1 (BIRIM_SURE=4) -> pompa high 28 cycles; 7 birim_darbe pulses 4 cycles apart; kalan 7..0; tamam one pulse at cycle 29; tuz_valf never high.
3. secim=1, miktar=6, tuzlu=1 -> pompa 24 cycles, then tuz_valf 3 cycles, then tamam; mesgul high 28 consecutive cycles.
4. secim=0, miktar=0, tuzlu=1 -> pompa never high, tuz_valf 3 cycles, tamam pulse. secim=0, tuzlu=0 -> tamam one cycle after accept, mesgul high 1 cycle.
5. bitti held high 500 cycles with the order from scenario 2 -> exactly one tamam. Then bitti low 1 cycle and high again -> second order served. A bitti edge during DAGIT -> ignored.
6. iptal=1 when kalan=3 -> next cycle pompa=0, kalan=0, mesgul=0, no tamam. A following bitti rising edge -> accepted normally.

Source files
------------

// File: rtl/malzeme_dagitici.sv
// -----------------------------------------------------------------------------
// malzeme_dagitici
// Consumer end of the ingredient-selection interface. One accepted order
// (selected line, unit count, salt flag) becomes a timed actuator sequence:
// the sauce pump runs BIRIM_SURE cycles per unit, then the salt valve opens
// for TUZ_SURE cycles, and finally a one-cycle completion pulse fires.
//
// Parameters:
//   BIRIM_SURE       clock cycles per dispensed unit (1..15)
//   TUZ_SURE         clock cycles the salt valve stays open (1..15)
//
// Ports:
//   saat             system clock, rising-edge active
//   reset_n          asynchronous active-low reset
//   bitti            order-valid level; a new order is its rising edge
//   secilen_malzeme  1 = sauce line selected
//   malzeme_miktari  units to dispense (0..15)
//   cikis_tuzlu      1 = add salt after pumping
//   iptal            synchronous abort, active-high
//   pompa            sauce pump enable
//   tuz_valf         salt valve enable
//   birim_darbe      one-cycle pulse in the last cycle of each unit
//   kalan            units still to dispense
//   mesgul           high whenever the block is not idle
//   tamam            one-cycle pulse when an order completes
// -----------------------------------------------------------------------------
module malzeme_dagitici #(
  parameter int BIRIM_SURE = 4,
  parameter int TUZ_SURE   = 3
) (
  input  logic       saat,
  input  logic       reset_n,
  input  logic       bitti,
  input  logic       secilen_malzeme,
  input  logic [3:0] malzeme_miktari,
  input  logic       cikis_tuzlu,
  input  logic       iptal,
  output logic       pompa,
  output logic       tuz_valf,
  output logic       birim_darbe,
  output logic [3:0] kalan,
  output logic       mesgul,
  output logic       tamam
);

  typedef enum logic [1:0] {
    BOS   = 2'd0,
    DAGIT = 2'd1,
    TUZ   = 2'd2,
    TAMAM = 2'd3
  } durum_t;

  localparam logic [3:0] BIRIM_SON = 4'(BIRIM_SURE - 1);
  localparam logic [3:0] TUZ_SON   = 4'(TUZ_SURE - 1);

  durum_t     durum, durum_n;
  logic       bitti_q;
  logic       tuzlu_q, tuzlu_n;
  logic [3:0] kalan_q, kalan_n;
  logic [3:0] sayac, sayac_n;
  logic       kabul;

  // A new order is a rising edge of bitti seen while idle; an abort in the
  // same cycle drops it.
  assign kabul = bitti & ~bitti_q & (durum == BOS) & ~iptal;

  always_ff @(posedge saat or negedge reset_n) begin
    if (!reset_n) begin
      durum   <= BOS;
      bitti_q <= 1'b0;
      tuzlu_q <= 1'b0;
      kalan_q <= 4'd0;
      sayac   <= 4'd0;
    end else begin
      durum   <= durum_n;
      bitti_q <= bitti;
      tuzlu_q <= tuzlu_n;
      kalan_q <= kalan_n;
      sayac   <= sayac_n;
    end
  end

  // Next-state logic. sayac is shared: it counts cycles within a unit in
  // DAGIT and valve-open cycles in TUZ, and is zeroed on every state entry.
  always_comb begin
    durum_n = durum;
    tuzlu_n = tuzlu_q;
    kalan_n = kalan_q;
    sayac_n = sayac;
    case (durum)
      BOS: begin
        if (kabul) begin
          tuzlu_n = cikis_tuzlu;
          sayac_n = 4'd0;
          if (secilen_malzeme && (malzeme_miktari != 4'd0)) begin
            durum_n = DAGIT;
            kalan_n = malzeme_miktari;
          end else if (cikis_tuzlu) begin
            durum_n = TUZ;
            kalan_n = 4'd0;
          end else begin
            durum_n = TAMAM;
            kalan_n = 4'd0;
          end
        end
      end
      DAGIT: begin
        if (sayac == BIRIM_SON) begin
          sayac_n = 4'd0;
          kalan_n = kalan_q - 4'd1;
          if (kalan_q == 4'd1) begin
            durum_n = tuzlu_q ? TUZ : TAMAM;
          end
        end else begin
          sayac_n = sayac + 4'd1;
        end
      end
      TUZ: begin
        if (sayac == TUZ_SON) begin
          sayac_n = 4'd0;
          durum_n = TAMAM;
        end else begin
          sayac_n = sayac + 4'd1;
        end
      end
      TAMAM: begin
        durum_n = BOS;
      end
      default: begin
        durum_n = BOS;
      end
    endcase
    // Abort overrides everything outside idle and skips the completion pulse.
    if (iptal && (durum != BOS)) begin
      durum_n = BOS;
      kalan_n = 4'd0;
      sayac_n = 4'd0;
    end
  end

  assign pompa       = (durum == DAGIT);
  assign birim_darbe = (durum == DAGIT) && (sayac == BIRIM_SON);
  assign tuz_valf    = (durum == TUZ);
  assign mesgul      = (durum != BOS);
  assign tamam       = (durum == TAMAM);
  assign kalan       = kalan_q;

endmodule

// File: tb/tb_malzeme_dagitici.sv
// -----------------------------------------------------------------------------
// tb_malzeme_dagitici
// Self-checking bench for malzeme_dagitici. Each order pushes its expected
// per-cycle output trace (built from the order fields) into a queue; the
// trace is popped and compared one cycle at a time as the DUT runs. A table
// of orders drives the main loop; reset, hold-high, and abort corners are
// hand-written sequences.
// -----------------------------------------------------------------------------
module tb_malzeme_dagitici;

  localparam int B = 4;
  localparam int T = 3;

  logic       saat = 1'b0;
  logic       reset_n = 1'b1;
  logic       bitti = 1'b0;
  logic       secilen_malzeme = 1'b0;
  logic [3:0] malzeme_miktari = 4'd0;
  logic       cikis_tuzlu = 1'b0;
  logic       iptal = 1'b0;
  logic       pompa, tuz_valf, birim_darbe, mesgul, tamam;
  logic [3:0] kalan;

  malzeme_dagitici #(.BIRIM_SURE(B), .TUZ_SURE(T)) dut (
    .saat            (saat),
    .reset_n         (reset_n),
    .bitti           (bitti),
    .secilen_malzeme (secilen_malzeme),
    .malzeme_miktari (malzeme_miktari),
    .cikis_tuzlu     (cikis_tuzlu),
    .iptal           (iptal),
    .pompa           (pompa),
    .tuz_valf        (tuz_valf),
    .birim_darbe     (birim_darbe),
    .kalan           (kalan),
    .mesgul          (mesgul),
    .tamam           (tamam)
  );

  always #5 saat = ~saat;

  typedef struct packed {
    logic       pompa;
    logic       tuz;
    logic       darbe;
    logic [3:0] kalan;
    logic       mesgul;
    logic       tamam;
  } out_t;

  typedef struct {
    logic       secim;
    logic [3:0] miktar;
    logic       tuzlu;
    logic       hold;
    logic       inject;
    int         exp_pompa;
    int         exp_tuz;
    int         exp_darbe;
    int         exp_mesgul;
  } vec_t;

  localparam out_t IDLE = '{pompa: 1'b0, tuz: 1'b0, darbe: 1'b0, kalan: 4'd0,
                            mesgul: 1'b0, tamam: 1'b0};

  out_t exp_q[$];
  vec_t vecs[9];
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic out_t mk(input logic p, input logic t, input logic d,
                              input logic [3:0] k, input logic m, input logic tm);
    out_t o;
    o.pompa = p; o.tuz = t; o.darbe = d; o.kalan = k; o.mesgul = m; o.tamam = tm;
    return o;
  endfunction

  task automatic step();
    @(posedge saat);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic [3:0] m, input logic t,
                               input logic b, input logic ip);
    secilen_malzeme = s;
    malzeme_miktari = m;
    cikis_tuzlu     = t;
    bitti           = b;
    iptal           = ip;
  endtask

  task automatic checkOutput(input string name, input out_t exp);
    out_t act;
    act = {pompa, tuz_valf, birim_darbe, kalan, mesgul, tamam};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: pompa/tuz/darbe/kalan/mesgul/tamam got %b/%b/%b/%0d/%b/%b want %b/%b/%b/%0d/%b/%b",
               name, act.pompa, act.tuz, act.darbe, act.kalan, act.mesgul, act.tamam,
               exp.pompa, exp.tuz, exp.darbe, exp.kalan, exp.mesgul, exp.tamam);
    end
  endtask

  task automatic checkCount(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Expected trace starting with the sample right after the accept edge.
  task automatic pushTrace(input logic s, input logic [3:0] m, input logic t);
    if (s && (m != 4'd0)) begin
      for (int u = int'(m); u >= 1; u--) begin
        for (int c = 0; c < B; c++) begin
          exp_q.push_back(mk(1'b1, 1'b0, (c == B - 1), 4'(u), 1'b1, 1'b0));
        end
      end
    end
    if (t) begin
      for (int c = 0; c < T; c++) exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0));
    end
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1));
    exp_q.push_back(IDLE);
  endtask

  task automatic runOrder(input string name, input vec_t v);
    int   idx;
    int   n_pompa, n_tuz, n_darbe, n_mesgul, n_tamam;
    out_t e;
    idx = 0; n_pompa = 0; n_tuz = 0; n_darbe = 0; n_mesgul = 0; n_tamam = 0;
    if (bitti) begin
      bitti = 1'b0;
      step();
      checkOutput({name, "_pre"}, IDLE);
    end
    applyStimulus(v.secim, v.miktar, v.tuzlu, 1'b1, 1'b0);
    pushTrace(v.secim, v.miktar, v.tuzlu);
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      checkOutput(name, e);
      n_pompa  += int'(pompa);
      n_tuz    += int'(tuz_valf);
      n_darbe  += int'(birim_darbe);
      n_mesgul += int'(mesgul);
      n_tamam  += int'(tamam);
      if (idx == 0) begin
        // Order fields are latched; disturbing them must change nothing.
        secilen_malzeme = ~v.secim;
        malzeme_miktari = ~v.miktar;
        cikis_tuzlu     = ~v.tuzlu;
        if (!v.hold) bitti = 1'b0;
      end
      if (v.inject && idx == 4) bitti = 1'b1;
      if (v.inject && idx == 6) bitti = 1'b0;
      idx++;
    end
    checkCount({name, "_pompa_cycles"}, n_pompa, v.exp_pompa);
    checkCount({name, "_tuz_cycles"}, n_tuz, v.exp_tuz);
    checkCount({name, "_darbe_pulses"}, n_darbe, v.exp_darbe);
    checkCount({name, "_mesgul_cycles"}, n_mesgul, v.exp_mesgul);
    checkCount({name, "_tamam_pulses"}, n_tamam, 1);
  endtask

  initial begin
    out_t e;
    vec_t hv;
    vecs[0] = '{1'b1, 4'd7,  1'b0, 1'b0, 1'b0, 28, 0, 7,  29};
    vecs[1] = '{1'b1, 4'd6,  1'b1, 1'b0, 1'b0, 24, 3, 6,  28};
    vecs[2] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 0,  3, 0,  4};
    vecs[3] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 0,  0, 0,  1};
    vecs[4] = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 0,  0, 0,  1};
    vecs[5] = '{1'b0, 4'd9,  1'b0, 1'b0, 1'b0, 0,  0, 0,  1};
    vecs[6] = '{1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 4,  0, 1,  5};
    vecs[7] = '{1'b1, 4'd15, 1'b1, 1'b0, 1'b0, 60, 3, 15, 64};
    vecs[8] = '{1'b1, 4'd3,  1'b0, 1'b0, 1'b1, 12, 0, 3,  13};

    // Reset state
    #2 reset_n = 1'b0;
    #1 checkOutput("reset_async", IDLE);
    step(); checkOutput("reset_hold", IDLE);
    reset_n = 1'b1;
    step(); checkOutput("reset_release_idle", IDLE);

    // Reset mid-order at kalan=5 acts without a clock edge
    applyStimulus(1'b1, 4'd7, 1'b0, 1'b1, 1'b0);
    pushTrace(1'b1, 4'd7, 1'b0);
    for (int i = 0; i < 9; i++) begin
      step();
      e = exp_q.pop_front();
      checkOutput("pre_reset_order", e);
    end
    exp_q.delete();
    #2 reset_n = 1'b0;
    #1 checkOutput("reset_mid_order", IDLE);
    bitti = 1'b0;
    step(); checkOutput("reset_mid_hold", IDLE);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); checkOutput("reset_release_bos", IDLE);
    end

    // bitti already high at reset release is accepted at the first edge
    reset_n = 1'b0;
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    step();
    reset_n = 1'b1;
    pushTrace(1'b0, 4'd0, 1'b0);
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      checkOutput("bitti_high_at_release", e);
    end

    // Table-driven orders
    for (int i = 0; i < 9; i++) begin
      runOrder($sformatf("vec%0d", i), vecs[i]);
    end

    // bitti held high through completion: exactly one order served
    hv = vecs[0];
    hv.hold = 1'b1;
    runOrder("hold_order", hv);
    for (int i = 0; i < 470; i++) begin
      step(); checkOutput("hold_no_retrigger", IDLE);
    end
    runOrder("hold_second_order", vecs[0]);

    // Abort at kalan=3
    applyStimulus(1'b1, 4'd7, 1'b0, 1'b1, 1'b0);
    pushTrace(1'b1, 4'd7, 1'b0);
    for (int i = 0; i < 17; i++) begin
      step();
      e = exp_q.pop_front();
      checkOutput("pre_abort_order", e);
      if (i == 0) bitti = 1'b0;
    end
    exp_q.delete();
    iptal = 1'b1;
    step(); checkOutput("abort_next", IDLE);
    iptal = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); checkOutput("abort_no_tamam", IDLE);
    end

    // Abort and rising bitti together: order dropped, held level ignored
    applyStimulus(1'b1, 4'd2, 1'b0, 1'b1, 1'b1);
    step(); checkOutput("abort_wins", IDLE);
    iptal = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); checkOutput("abort_dropped", IDLE);
    end
    runOrder("after_abort", vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
